// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings for the multicycle MIPS core
// Purpose: opcode/funct constants, FSM state enum and the 3-bit ALU control
// encoding used by multicycle_mips_core and its register file.
// Ports: none (package).
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_WB_MEM, S_MEMWR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic alu_ctl_t funct_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// rtl/mips_mc_regfile.sv - 32x32 register file with debug read port
// Purpose: two asynchronous read ports, one debug read port, one synchronous
// write port; register 0 always reads 0 and ignores writes.
// Ports: clk, areset (async active-low), ra1/ra2 -> rd1/rd2 read ports,
// we/wa/wd write port, dbg_sel -> dbg_data debug read.
module mips_mc_regfile (
  input  logic        clk,
  input  logic        areset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 5'd0)     ? 32'd0 : regs[ra1];
  assign rd2      = (ra2 == 5'd0)     ? 32'd0 : regs[ra2];
  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : regs[dbg_sel];

endmodule

// File: rtl/multicycle_mips_core.sv
// rtl/multicycle_mips_core.sv - multicycle MIPS core with shared ALU and memory port
// Purpose: one FSM sequences fetch/decode/execute/memory/writeback over a single
// unified req/ready memory port and one ALU. Optional macro ILLEGAL_TRAP_EN adds
// output illegal and halts on unsupported encodings (otherwise they are NOPs).
// Ports: clk, areset (async active-low); mem_req/mem_we/mem_addr/mem_wdata out,
// mem_rdata/mem_ready in; pc, instr_retired out; dbg_reg_sel in, dbg_reg_data out;
// illegal out (ILLEGAL_TRAP_EN only).
module multicycle_mips_core
  import mips_mc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              areset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W+1:0] pc,
`ifdef ILLEGAL_TRAP_EN
  output logic              illegal,
`endif
  output logic              instr_retired,
  input  logic [4:0]        dbg_reg_sel,
  output logic [31:0]       dbg_reg_data
);

  localparam int PC_W = ADDR_W + 2;
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir, a_q, b_q, alu_out, mdr, br_tgt;
  logic [31:0]     rd1, rd2, imm_sx, pc_ext, jmp_tgt;
  logic [31:0]     alu_a, alu_b, alu_y;
  alu_ctl_t        alu_ctl;
  logic            req, we, retire, rf_we;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd;

  wire [5:0] op = ir[31:26];
  wire [4:0] rs = ir[25:21];
  wire [4:0] rt = ir[20:16];
  wire [4:0] rd = ir[15:11];

  assign imm_sx  = {{16{ir[15]}}, ir[15:0]};
  assign pc_ext  = 32'(pc_q);
  assign jmp_tgt = {pc_ext[31:28], ir[25:0], 2'b00};

  mips_mc_regfile u_rf (
    .clk(clk), .areset(areset),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd),
    .dbg_sel(dbg_reg_sel), .dbg_data(dbg_reg_data)
  );

  // Single shared ALU; operand selection is done by the FSM below.
  always_comb begin
    case (alu_ctl)
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // Request is decoded from state alone so mem_ready never feeds back into it.
  assign req = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign we  = (state == S_MEMWR);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= S_FETCH;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    alu_a    = pc_ext;
    alu_b    = 32'd4;
    alu_ctl  = ALU_ADD;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = rt;
    rf_wd    = alu_out;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        alu_b = {imm_sx[29:0], 2'b00};
        if (op == OP_RTYPE && funct_ok(ir[5:0])) state_nx = S_EXEC_R;
        else if (op == OP_LW || op == OP_SW)     state_nx = S_MEMADR;
        else if (op == OP_ADDI)                  state_nx = S_EXEC_I;
        else if (op == OP_BEQ)                   state_nx = S_BRANCH;
        else if (op == OP_J)                     state_nx = S_JUMP;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_nx = S_HALT;
`else
          state_nx = S_FETCH;
          retire   = 1'b1;
`endif
        end
      end
      S_MEMADR: begin
        alu_a    = a_q;
        alu_b    = imm_sx;
        state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD:  if (mem_ready) state_nx = S_WB_MEM;
      S_WB_MEM: begin
        rf_we = 1'b1; rf_wd = mdr; retire = 1'b1; state_nx = S_FETCH;
      end
      S_MEMWR: if (mem_ready) begin
        retire = 1'b1; state_nx = S_FETCH;
      end
      S_EXEC_R: begin
        alu_a = a_q; alu_b = b_q; alu_ctl = funct_alu(ir[5:0]); state_nx = S_WB_R;
      end
      S_WB_R: begin
        rf_we = 1'b1; rf_wa = rd; retire = 1'b1; state_nx = S_FETCH;
      end
      S_EXEC_I: begin
        alu_a = a_q; alu_b = imm_sx; state_nx = S_WB_I;
      end
      S_WB_I: begin
        rf_we = 1'b1; retire = 1'b1; state_nx = S_FETCH;
      end
      S_BRANCH: begin
        alu_a = a_q; alu_b = b_q; alu_ctl = ALU_SUB; retire = 1'b1; state_nx = S_FETCH;
      end
      S_JUMP: begin
        retire = 1'b1; state_nx = S_FETCH;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pc_q    <= PC_RST;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      br_tgt  <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir   <= mem_rdata;
          pc_q <= alu_y[PC_W-1:0];
        end
        S_DECODE: begin
          a_q    <= rd1;
          b_q    <= rd2;
          br_tgt <= alu_y;
        end
        S_MEMADR, S_EXEC_R, S_EXEC_I: alu_out <= alu_y;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_BRANCH: if (alu_y == 32'd0) pc_q <= br_tgt[PC_W-1:0];
        S_JUMP:   pc_q <= jmp_tgt[PC_W-1:0];
        default:  ;
      endcase
    end
  end

  // Outputs are forced to 0 while areset is low so a reset mid-access
  // withdraws the request in the same instant.
  assign mem_req       = areset & req;
  assign mem_we        = mem_req & we;
  assign mem_addr      = !mem_req ? '0 :
                         (state == S_FETCH) ? pc_q[PC_W-1:2] : alu_out[PC_W-1:2];
  assign mem_wdata     = mem_we ? b_q : 32'd0;
  assign instr_retired = areset & retire;
  assign pc            = pc_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal       = (state == S_HALT);
`endif

endmodule

// File: tb/tb_multicycle_mips_core.sv
// tb/tb_multicycle_mips_core.sv - scoreboard bench for multicycle_mips_core
`timescale 1ns/1ps
module tb_multicycle_mips_core;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              areset = 1'b0;
  logic              mem_req, mem_we, mem_ready, instr_retired;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, dbg_reg_data;
  logic [ADDR_W+1:0] pc;
  logic [4:0]        dbg_reg_sel = 5'd0;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal;
`endif

  multicycle_mips_core #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk(clk), .areset(areset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .instr_retired(instr_retired),
    .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, prev_cyc = -1;
  int lat = 0, wait_cnt = 0;
  logic [31:0] mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model with programmable latency: ready after 'lat' waiting cycles.
  assign mem_ready = mem_req && (wait_cnt >= lat);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ready) begin
      wait_cnt <= 0;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end else if (mem_req) wait_cnt <= wait_cnt + 1;
    else                  wait_cnt <= 0;
  end

  // A waiting request must hold address, direction and data.
  logic [ADDR_W-1:0] h_addr;
  logic              h_we;
  logic [31:0]       h_wdata;
  always @(negedge clk) begin
    if (areset && mem_req) begin
      if (wait_cnt > 0) begin
        check("hold_addr", 32'(mem_addr), 32'(h_addr));
        check("hold_we", 32'(mem_we), 32'(h_we));
        check("hold_wdata", mem_wdata, h_wdata);
      end else begin
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
      end
    end
  end

  typedef struct {
    logic [9:0]  pc;
    logic [4:0]  r;
    logic [31:0] v;
    int          cpi;
  } exp_t;
  exp_t q[$];

  task automatic expect_ret(input logic [9:0] p, input logic [4:0] r,
                            input logic [31:0] v, input int cpi);
    exp_t e;
    e.pc = p; e.r = r; e.v = v; e.cpi = cpi;
    q.push_back(e);
  endtask

  // Scoreboard: each retired pulse pops one expectation; PC and register
  // are compared just after the retiring edge.
  initial begin : monitor
    exp_t e;
    int   dcyc;
    forever begin
      @(negedge clk);
      if (areset && instr_retired) begin
        dcyc = cyc - prev_cyc;
        if (q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
          prev_cyc = cyc;
        end else begin
          e = q.pop_front();
          if (e.cpi != 0 && prev_cyc >= 0) check("cpi", 32'(dcyc), 32'(e.cpi));
          prev_cyc = cyc;
          @(posedge clk); #1;
          dbg_reg_sel = e.r;
          #1;
          check("retire_pc", 32'(pc), 32'(e.pc));
          check("retire_reg", dbg_reg_data, e.v);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000;
  endtask

  task automatic release_reset();
    prev_cyc = -1;
    @(posedge clk); #3;
    areset = 1'b1;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #3;
    areset = 1'b0;
    repeat (2) @(posedge clk);
    #3;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int found;
    clear_mem();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retired", 32'(instr_retired), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    check("rst_illegal", 32'(illegal), 32'd0);
`endif

    // ALU ops, $0 write, store/load, branches, jumps and PC wrap, ready=1.
    lat = 0;
    mem[0]   = enc_i(6'h08, 0, 1, 16'd5);        expect_ret(10'h004, 1, 32'd5, 0);
    mem[1]   = enc_i(6'h08, 0, 2, 16'd7);        expect_ret(10'h008, 2, 32'd7, 4);
    mem[2]   = enc_r(3, 1, 2, 6'h20);            expect_ret(10'h00C, 3, 32'd12, 4);
    mem[3]   = enc_r(5, 1, 2, 6'h22);            expect_ret(10'h010, 5, 32'hFFFF_FFFE, 4);
    mem[4]   = enc_r(6, 1, 2, 6'h24);            expect_ret(10'h014, 6, 32'd5, 4);
    mem[5]   = enc_r(7, 1, 2, 6'h25);            expect_ret(10'h018, 7, 32'd7, 4);
    mem[6]   = enc_i(6'h08, 0, 8, 16'hFFFF);     expect_ret(10'h01C, 8, 32'hFFFF_FFFF, 4);
    mem[7]   = enc_r(9, 8, 1, 6'h2A);            expect_ret(10'h020, 9, 32'd1, 4);
    mem[8]   = enc_r(10, 1, 8, 6'h2A);           expect_ret(10'h024, 10, 32'd0, 4);
    mem[9]   = enc_i(6'h08, 0, 0, 16'd9);        expect_ret(10'h028, 0, 32'd0, 4);
    mem[10]  = enc_i(6'h2B, 0, 3, 16'h0200);     expect_ret(10'h02C, 3, 32'd12, 4);
    mem[11]  = enc_i(6'h23, 0, 4, 16'h0200);     expect_ret(10'h030, 4, 32'd12, 5);
    mem[12]  = enc_i(6'h04, 1, 1, 16'd2);        expect_ret(10'h03C, 1, 32'd5, 3);
    mem[15]  = enc_i(6'h04, 1, 2, 16'd5);        expect_ret(10'h040, 2, 32'd7, 3);
    mem[16]  = enc_j(26'h3F);                    expect_ret(10'h0FC, 3, 32'd12, 3);
    mem[63]  = enc_j(26'hFF);                    expect_ret(10'h3FC, 6, 32'd5, 3);
    mem[255] = enc_i(6'h08, 0, 11, 16'd3);       expect_ret(10'h000, 11, 32'd3, 4);
    release_reset();
    run_until_empty(400);
    check("store_word", mem[128], 32'd12);
    dbg_reg_sel = 5'd1;
    #1;
    check("rst_reg_cleared", dbg_reg_data, 32'd0);

    // Store then load with 3 wait cycles on every access.
    clear_mem();
    lat = 3;
    mem[0] = enc_i(6'h08, 0, 3, 16'd12);         expect_ret(10'h004, 3, 32'd12, 0);
    mem[1] = enc_i(6'h2B, 0, 3, 16'h0200);       expect_ret(10'h008, 3, 32'd12, 0);
    mem[2] = enc_i(6'h23, 0, 4, 16'h0200);       expect_ret(10'h00C, 4, 32'd12, 0);
    release_reset();
    run_until_empty(400);
    check("store_word_slow", mem[128], 32'd12);

    // Unsupported encodings: NOP by default, HALT with the trap option.
    clear_mem();
    lat = 0;
    mem[0] = 32'hFC00_0000;
    mem[1] = 32'h0000_0000;
    mem[2] = enc_i(6'h08, 0, 1, 16'd1);
`ifdef ILLEGAL_TRAP_EN
    release_reset();
    repeat (12) @(negedge clk);
    check("halt_illegal", 32'(illegal), 32'd1);
    check("halt_mem_req", 32'(mem_req), 32'd0);
    check("halt_pc", 32'(pc), 32'h004);
    run_until_empty(10);
`else
    expect_ret(10'h004, 0, 32'd0, 0);
    expect_ret(10'h008, 0, 32'd0, 2);
    expect_ret(10'h00C, 1, 32'd1, 4);
    release_reset();
    run_until_empty(200);
`endif

    // Reset while a load waits in MEMRD, then refetch from RESET_PC.
    clear_mem();
    lat = 5;
    mem[0]   = enc_i(6'h23, 0, 4, 16'h0200);
    mem[128] = 32'hDEAD_BEEF;
    release_reset();
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 8'h80) found = 1;
    end
    check("reach_memrd", 32'(found), 32'd1);
    #1;
    areset = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    lat = 0;
    expect_ret(10'h004, 4, 32'hDEAD_BEEF, 0);
    release_reset();
    @(negedge clk);
    check("refetch_req", 32'(mem_req), 32'd1);
    check("refetch_addr", 32'(mem_addr), 32'd0);
    check("refetch_we", 32'(mem_we), 32'd0);
    run_until_empty(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_mips_core.md
Name: multicycle_mips_core

Overview:
Parametrised multicycle successor to the single-cycle MIPS top. One FSM sequences fetch/decode/execute/memory/writeback over several cycles, sharing one ALU and one unified instruction/data memory port. The memory port uses a req/ready handshake, so the core tolerates variable-latency memory. It contains its own register file, ALU and control.

Parameters:
ADDR_W, 8, word-address width of unified memory (PC is ADDR_W+2 bits, byte-addressed)
RESET_PC, 0, PC value loaded at reset (byte address, multiple of 4)

Ports:
clk  in  1  clock, rising edge
areset  in  1  asynchronous, active-low reset
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid in the accept cycle
mem_ready  in  1  request accepted (mem_req && mem_ready)
pc  out  ADDR_W+2  current PC
instr_retired  out  1  one-cycle pulse on instruction completion
dbg_reg_sel  in  5  debug register index
dbg_reg_data  out  32  combinational read of register dbg_reg_sel ($0 reads 0)

Behaviour:
- Reset, asynchronous on areset low: pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_retired=0, all registers 0. A reset mid-access drops mem_req immediately; the pending transaction is abandoned.
- ISA: add, sub, and, or, slt (R-type, op 0); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
- Other opcodes or functs execute as NOP: FETCH→DECODE→FETCH, PC+4, retired pulse.
- States and transitions:
  - FETCH → DECODE. mem_req=1, we=0, addr=pc[ADDR_W+1:2]. On accept: IR←rdata, pc←pc+4.
  - DECODE → (op dependent). Read rs/rt into A/B. Compute branch target = pc + (sext(imm)<<2).
  - R-type: EXEC_R → WB_R → FETCH.
  - lw/sw: MEMADR; lw → MEMRD → WB_MEM → FETCH; sw → MEMWR → FETCH.
  - addi: EXEC_I → WB_I → FETCH.
  - beq: BRANCH → FETCH. Taken if A==B.
  - j: JUMP → FETCH. pc ← {pc[ADDR_W+1:28 when present], target26<<2}, truncated to ADDR_W+2 bits.
- Memory handshake:
  - FETCH, MEMRD and MEMWR hold mem_req and address/data stable until mem_ready.
  - The state advances only on accept. mem_ready is ignored when mem_req=0.
  - Combinational same-cycle ready is legal.
- CPI with ready tied 1: R 4, lw 5, sw 4, addi 4, beq 3, j 3.
- instr_retired pulses in the final state of each instruction.
- Arithmetic:
  - 32-bit two's complement; add/sub wrap, no overflow trap.
  - slt is signed.
  - addi sign-extends imm16.
  - lw/sw effective address = A+sext(imm); word address = bits [ADDR_W+1:2]; low two bits ignored.
- PC wraps modulo 2^(ADDR_W+2).
- Writes to $0 are discarded.
- Register write occurs in the WB state, on the same edge as the retired pulse.

Optional Feature:
ILLEGAL_TRAP_EN: when defined, adds output illegal (1 bit, reset 0).
- With the feature: an unsupported opcode/funct enters HALT. illegal=1, mem_req=0, no retired pulse, pc = faulting PC+4. The core stays in HALT until reset.
- Without the feature: unsupported encodings are NOPs as above.

Decomposition:
- Package mips_mc_pkg: opcode and funct localparams, FSM state enum, 3-bit ALU-control encoding.
- Sub-module mips_mc_regfile: 32x32, two async read ports plus a debug read port, one sync write port, $0 hardwired to 0.
- ALU and FSM stay in the core.

Test Plan:
1. Memory words 0..2 = addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; mem_ready=1 → retired pulses every 4 cycles; dbg $3=12; pc=12 after the third.
2. sw $3,16($0) then lw $4,16($0); mem_ready asserted 3 cycles after each req → word 4 = 12; $4=12; mem_addr/we/wdata stable while waiting.
3. beq $1,$1,+2 at pc 0x10 → next fetch at 0x1C. beq $1,$2 not taken → next fetch at 0x14; 3 cycles each.
4. j to word 0x3F with ADDR_W=8 → pc=0xFC. Instruction at 0xFC is addi → next pc wraps to 0x00.
5. addi $0,$0,9 → dbg $0=0. slt with $1=-1, $2=1 → 1.
6. Assert areset low during a lw with MEMRD waiting → mem_req low immediately; pc=RESET_PC; refetch from RESET_PC after release. Under ILLEGAL_TRAP_EN, opcode 0x3F → illegal=1, mem_req held 0.
